// File: rtl/pipe_fwd_ctl_pkg.sv
// Purpose : shared constants and select helper for the ID-stage hazard/forwarding controller.
// Latency : n/a (definitions only).
// Backpressure: n/a.
package pipe_ctl_pkg;

  localparam int RA_W = 5;

  // EXE operand select encodings; A and B share the numeric codes.
  localparam logic [1:0] DEP_REG  = 2'b00;  // register-file operand (ea / eb)
  localparam logic [1:0] DEP_ALT  = 2'b01;  // shift amount (A) or immediate (B)
  localparam logic [1:0] DEP_MALU = 2'b10;  // result of the instruction now in EXE
  localparam logic [1:0] DEP_WDI  = 2'b11;  // write-back data of the instruction now in MEM

  localparam logic [RA_W-1:0] REG_RA = 5'd31;  // jal link register

  // Operand select with priority: alternate source, then the youngest producer
  // (EXE), then the older one (MEM), else the register file.
  function automatic logic [1:0] dep_sel(input logic alt, input logic hit_e, input logic hit_m);
    if (alt)        return DEP_ALT;
    else if (hit_e) return DEP_MALU;
    else if (hit_m) return DEP_WDI;
    else            return DEP_REG;
  endfunction

endpackage

// File: rtl/pipe_fwd_ctl_if.sv
// Purpose : ID-stage decode inputs and hazard/forwarding outputs of pipe_fwd_ctl.
// Latency : n/a (signal bundle); master = decode side, slave = controller.
// Backpressure: stall (combinational) freezes PC and IF/ID; flush squashes ID.
interface pipe_fwd_ctl_if #(
  parameter int RA_W  = 5,
  parameter int DEP_W = 2,
  parameter int CNT_W = 32
);
  logic             id_valid;
  logic [RA_W-1:0]  id_rs;
  logic [RA_W-1:0]  id_rt;
  logic [RA_W-1:0]  id_rn;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_wreg;
  logic             id_m2reg;
  logic             id_shift;
  logic             id_aluimm;
  logic             id_jal;
  logic             flush;

  logic             stall;
  logic [DEP_W-1:0] ea_depen;
  logic [DEP_W-1:0] eb_depen;
  logic [RA_W-1:0]  ern;
  logic             ewreg;
  logic             em2reg;
  logic [RA_W-1:0]  mrn;
  logic             mwreg;
  logic             mm2reg;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_rn, id_use_rs, id_use_rt,
           id_wreg, id_m2reg, id_shift, id_aluimm, id_jal, flush,
    input  stall, ea_depen, eb_depen, ern, ewreg, em2reg,
           mrn, mwreg, mm2reg, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rn, id_use_rs, id_use_rt,
           id_wreg, id_m2reg, id_shift, id_aluimm, id_jal, flush,
    output stall, ea_depen, eb_depen, ern, ewreg, em2reg,
           mrn, mwreg, mm2reg, stall_cnt
  );

endinterface

// File: rtl/pipe_fwd_ctl_dst_stage.sv
// Purpose : one pipeline stage of destination tracking {rn, wreg, m2reg}.
// Latency : 1 cycle; bubble or reset loads rn 0 / wreg 0 / m2reg 0.
// Backpressure: none; loads every clock.
// Ports: clock, reset (sync, active-high), bubble, src_* (next-stage values), rn/wreg/m2reg (registered).
module pipe_dst_stage #(
  parameter int RA_W = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            bubble,
  input  logic [RA_W-1:0] src_rn,
  input  logic            src_wreg,
  input  logic            src_m2reg,
  output logic [RA_W-1:0] rn,
  output logic            wreg,
  output logic            m2reg
);

  always_ff @(posedge clock) begin
    if (reset || bubble) begin
      rn    <= '0;
      wreg  <= 1'b0;
      m2reg <= 1'b0;
    end else begin
      rn    <= src_rn;
      wreg  <= src_wreg;
      m2reg <= src_m2reg;
    end
  end

endmodule

// File: rtl/pipe_fwd_ctl.sv
// Purpose : ID-stage hazard/forwarding controller; registered EXE operand selects and E/M destination tracking.
// Latency : depen/E/M outputs 1 cycle after ID; stall is combinational from ID inputs and E state.
// Backpressure: load-use raises stall for exactly one cycle and bubbles E; flush overrides stall and bubbles E.
// Ports: clock, reset (sync, active-high), fwd (pipe_fwd_ctl_if.slave).
// Option: define STALL_CNT_EN to build a saturating stall-cycle counter; otherwise stall_cnt is tied to 0.
module pipe_fwd_ctl #(
  parameter int RA_W  = 5,
  parameter int DEP_W = 2,
  parameter int CNT_W = 32
) (
  input  logic           clock,
  input  logic           reset,
  pipe_fwd_ctl_if.slave  fwd
);
  import pipe_ctl_pkg::*;

  // Forwarding match against one producer stage; r0 is hard-wired zero so it never matches.
  function automatic logic hit(input logic wr, input logic [RA_W-1:0] prod_rn, input logic [RA_W-1:0] r);
    return wr && (prod_rn != '0) && (prod_rn == r);
  endfunction

  logic [RA_W-1:0]  e_rn;
  logic             e_wreg;
  logic             e_m2reg;
  logic [RA_W-1:0]  m_rn;
  logic             m_wreg;
  logic             m_m2reg;
  logic [RA_W-1:0]  id_dst;
  logic             hit_e_rs;
  logic             hit_e_rt;
  logic             hit_m_rs;
  logic             hit_m_rt;
  logic             stall_w;
  logic             e_bubble;
  logic [DEP_W-1:0] ea_nxt;
  logic [DEP_W-1:0] eb_nxt;
  logic [DEP_W-1:0] ea_q;
  logic [DEP_W-1:0] eb_q;

  assign id_dst = fwd.id_jal ? RA_W'(REG_RA) : fwd.id_rn;

  assign hit_e_rs = hit(e_wreg, e_rn, fwd.id_rs);
  assign hit_e_rt = hit(e_wreg, e_rn, fwd.id_rt);
  assign hit_m_rs = hit(m_wreg, m_rn, fwd.id_rs);
  assign hit_m_rt = hit(m_wreg, m_rn, fwd.id_rt);

  // A load in EXE has no data until MEM completes, so a consumer in ID waits one
  // cycle; it then sees the load in MEM and picks up wdi. Flush squashes the
  // consumer anyway, so it never needs to stall.
  assign stall_w = fwd.id_valid && !fwd.flush && e_m2reg &&
                   ((fwd.id_use_rs && hit_e_rs) || (fwd.id_use_rt && hit_e_rt));

  assign e_bubble = stall_w || fwd.flush || !fwd.id_valid;

  assign ea_nxt = DEP_W'(dep_sel(fwd.id_shift,  hit_e_rs, hit_m_rs));
  assign eb_nxt = DEP_W'(dep_sel(fwd.id_aluimm, hit_e_rt, hit_m_rt));

  always_ff @(posedge clock) begin
    if (reset || e_bubble) begin
      ea_q <= DEP_W'(DEP_REG);
      eb_q <= DEP_W'(DEP_REG);
    end else begin
      ea_q <= ea_nxt;
      eb_q <= eb_nxt;
    end
  end

  pipe_dst_stage #(.RA_W(RA_W)) u_e_stage (
    .clock     (clock),
    .reset     (reset),
    .bubble    (e_bubble),
    .src_rn    (id_dst),
    .src_wreg  (fwd.id_wreg),
    .src_m2reg (fwd.id_m2reg),
    .rn        (e_rn),
    .wreg      (e_wreg),
    .m2reg     (e_m2reg)
  );

  // Bubbles only enter at E; MEM simply follows EXE.
  pipe_dst_stage #(.RA_W(RA_W)) u_m_stage (
    .clock     (clock),
    .reset     (reset),
    .bubble    (1'b0),
    .src_rn    (e_rn),
    .src_wreg  (e_wreg),
    .src_m2reg (e_m2reg),
    .rn        (m_rn),
    .wreg      (m_wreg),
    .m2reg     (m_m2reg)
  );

`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (stall_w && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign fwd.stall_cnt = stall_cnt_q;
`else
  assign fwd.stall_cnt = '0;
`endif

  assign fwd.stall    = stall_w;
  assign fwd.ea_depen = ea_q;
  assign fwd.eb_depen = eb_q;
  assign fwd.ern      = e_rn;
  assign fwd.ewreg    = e_wreg;
  assign fwd.em2reg   = e_m2reg;
  assign fwd.mrn      = m_rn;
  assign fwd.mwreg    = m_wreg;
  assign fwd.mm2reg   = m_m2reg;

endmodule

// File: tb/tb_pipe_fwd_ctl.sv
// Purpose : directed self-checking bench for pipe_fwd_ctl.
// Latency : inputs driven 1ns after the rising edge; registered outputs sampled 1ns after the next edge.
// Backpressure: stall is checked 1ns after inputs settle.
module tb_pipe_fwd_ctl;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  pipe_fwd_ctl_if bus ();

  pipe_fwd_ctl dut (
    .clock (clk),
    .reset (reset),
    .fwd   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rn,
                        input logic use_rs, input logic use_rt, input logic wreg, input logic m2reg,
                        input logic shift, input logic aluimm, input logic jal);
    bus.id_valid  = 1'b1;
    bus.id_rs     = rs;
    bus.id_rt     = rt;
    bus.id_rn     = rn;
    bus.id_use_rs = use_rs;
    bus.id_use_rt = use_rt;
    bus.id_wreg   = wreg;
    bus.id_m2reg  = m2reg;
    bus.id_shift  = shift;
    bus.id_aluimm = aluimm;
    bus.id_jal    = jal;
    bus.flush     = 1'b0;
  endtask

  task automatic set_nop();
    set_id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.id_valid = 1'b0;
  endtask

  task automatic do_reset();
    set_nop();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    // A valid load sits in ID while reset is high; E must still clear.
    set_id(5'd1, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    reset = 1'b1;
    step();
    step();
    n_chk++; if (bus.ern !== 5'd0)   begin n_fail++; $display("FAIL reset_ern: got %0d want 0", bus.ern); end
    n_chk++; if (bus.ewreg !== 1'b0) begin n_fail++; $display("FAIL reset_ewreg: got %0b want 0", bus.ewreg); end
    n_chk++; if (bus.em2reg !== 1'b0) begin n_fail++; $display("FAIL reset_em2reg: got %0b want 0", bus.em2reg); end
    n_chk++; if (bus.mrn !== 5'd0)   begin n_fail++; $display("FAIL reset_mrn: got %0d want 0", bus.mrn); end
    n_chk++; if (bus.mwreg !== 1'b0) begin n_fail++; $display("FAIL reset_mwreg: got %0b want 0", bus.mwreg); end
    n_chk++; if (bus.mm2reg !== 1'b0) begin n_fail++; $display("FAIL reset_mm2reg: got %0b want 0", bus.mm2reg); end
    n_chk++; if (bus.ea_depen !== 2'b00) begin n_fail++; $display("FAIL reset_ea: got %0b want 00", bus.ea_depen); end
    n_chk++; if (bus.eb_depen !== 2'b00) begin n_fail++; $display("FAIL reset_eb: got %0b want 00", bus.eb_depen); end
    n_chk++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b want 0", bus.stall); end
    n_chk++; if (bus.stall_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", bus.stall_cnt); end
    reset = 1'b0;
  endtask

  task automatic test_e_fwd();
    do_reset();
    set_id(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);   // add r3,r1,r2
    step();
    set_id(5'd3, 5'd5, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);   // sub r4,r3,r5
    #1;
    n_chk++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL efwd_stall: got %0b want 0", bus.stall); end
    step();
    n_chk++; if (bus.ea_depen !== 2'b10) begin n_fail++; $display("FAIL efwd_ea: got %0b want 10", bus.ea_depen); end
    n_chk++; if (bus.eb_depen !== 2'b00) begin n_fail++; $display("FAIL efwd_eb: got %0b want 00", bus.eb_depen); end
    n_chk++; if (bus.ern !== 5'd4) begin n_fail++; $display("FAIL efwd_ern: got %0d want 4", bus.ern); end
    n_chk++; if (bus.mrn !== 5'd3 || bus.mwreg !== 1'b1) begin n_fail++; $display("FAIL efwd_m: got rn %0d wreg %0b want 3 1", bus.mrn, bus.mwreg); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(5'd1, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);   // lw r3
    step();
    set_id(5'd3, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);   // add r4,r3,r3
    #1;
    n_chk++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall1: got %0b want 1", bus.stall); end
    step();
    n_chk++; if (bus.ewreg !== 1'b0 || bus.ern !== 5'd0 || bus.em2reg !== 1'b0) begin n_fail++; $display("FAIL lu_bubble: got ern %0d ewreg %0b em2reg %0b want 0 0 0", bus.ern, bus.ewreg, bus.em2reg); end
    n_chk++; if (bus.ea_depen !== 2'b00) begin n_fail++; $display("FAIL lu_bubble_ea: got %0b want 00", bus.ea_depen); end
    n_chk++; if (bus.mrn !== 5'd3 || bus.mm2reg !== 1'b1) begin n_fail++; $display("FAIL lu_m: got rn %0d m2reg %0b want 3 1", bus.mrn, bus.mm2reg); end
    n_chk++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall2: got %0b want 0", bus.stall); end
    step();
    n_chk++; if (bus.ea_depen !== 2'b11) begin n_fail++; $display("FAIL lu_ea: got %0b want 11", bus.ea_depen); end
    n_chk++; if (bus.eb_depen !== 2'b11) begin n_fail++; $display("FAIL lu_eb: got %0b want 11", bus.eb_depen); end
    n_chk++; if (bus.ern !== 5'd4 || bus.ewreg !== 1'b1) begin n_fail++; $display("FAIL lu_e: got rn %0d wreg %0b want 4 1", bus.ern, bus.ewreg); end
  endtask

  task automatic test_r0();
    do_reset();
    set_id(5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);   // lw r0
    step();
    set_id(5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);   // add r8,r0,r0
    #1;
    n_chk++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL r0_stall: got %0b want 0", bus.stall); end
    step();
    n_chk++; if (bus.ea_depen !== 2'b00 || bus.eb_depen !== 2'b00) begin n_fail++; $display("FAIL r0_depen: got %0b %0b want 00 00", bus.ea_depen, bus.eb_depen); end
    n_chk++; if (bus.ern !== 5'd8) begin n_fail++; $display("FAIL r0_ern: got %0d want 8", bus.ern); end
  endtask

  task automatic test_e_wins();
    do_reset();
    set_id(5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);   // add r7
    step();
    step();                                                                // second add r7
    set_id(5'd7, 5'd7, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    n_chk++; if (bus.ea_depen !== 2'b10 || bus.eb_depen !== 2'b10) begin n_fail++; $display("FAIL ewins: got %0b %0b want 10 10", bus.ea_depen, bus.eb_depen); end
  endtask

  task automatic test_two_ahead();
    do_reset();
    set_id(5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);   // add r7
    step();
    set_nop();
    step();
    n_chk++; if (bus.ewreg !== 1'b0) begin n_fail++; $display("FAIL two_nop: got ewreg %0b want 0", bus.ewreg); end
    set_id(5'd7, 5'd7, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    n_chk++; if (bus.ea_depen !== 2'b11 || bus.eb_depen !== 2'b11) begin n_fail++; $display("FAIL two_ahead: got %0b %0b want 11 11", bus.ea_depen, bus.eb_depen); end
  endtask

  task automatic test_jal();
    do_reset();
    set_id(5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    n_chk++; if (bus.ern !== 5'd31 || bus.ewreg !== 1'b1) begin n_fail++; $display("FAIL jal: got rn %0d wreg %0b want 31 1", bus.ern, bus.ewreg); end
  endtask

  task automatic test_shift_imm();
    do_reset();
    set_id(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);   // add r3
    step();
    set_id(5'd3, 5'd6, 5'd10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);  // shift, rs=r3
    step();
    n_chk++; if (bus.ea_depen !== 2'b01 || bus.eb_depen !== 2'b00) begin n_fail++; $display("FAIL shift: got %0b %0b want 01 00", bus.ea_depen, bus.eb_depen); end
    // r3 now in M, r10 in E: A forwards wdi, B takes the immediate.
    set_id(5'd3, 5'd3, 5'd11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    n_chk++; if (bus.ea_depen !== 2'b11 || bus.eb_depen !== 2'b01) begin n_fail++; $display("FAIL aluimm: got %0b %0b want 11 01", bus.ea_depen, bus.eb_depen); end
  endtask

  task automatic test_stall_flush();
    do_reset();
    set_id(5'd1, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);   // lw r3
    step();
    set_id(5'd3, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.flush = 1'b1;
    #1;
    n_chk++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL sf_stall: got %0b want 0", bus.stall); end
    step();
    n_chk++; if (bus.ewreg !== 1'b0 || bus.ern !== 5'd0 || bus.ea_depen !== 2'b00) begin n_fail++; $display("FAIL sf_bubble: got ern %0d ewreg %0b ea %0b want 0 0 00", bus.ern, bus.ewreg, bus.ea_depen); end
    bus.flush = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_id(5'd1, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);   // lw r3
    step();
    set_id(5'd3, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    n_chk++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL rms_stall1: got %0b want 1", bus.stall); end
    reset = 1'b1;
    step();
    n_chk++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL rms_stall2: got %0b want 0", bus.stall); end
    n_chk++; if (bus.mrn !== 5'd0 || bus.em2reg !== 1'b0) begin n_fail++; $display("FAIL rms_clear: got mrn %0d em2reg %0b want 0 0", bus.mrn, bus.em2reg); end
    reset = 1'b0;
  endtask

  task automatic test_stall_cnt();
    logic [31:0] exp_cnt;
`ifdef STALL_CNT_EN
    exp_cnt = 32'd3;
`else
    exp_cnt = 32'd0;
`endif
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_id(5'd1, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      step();
      set_id(5'd3, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      step();
    end
    n_chk++; if (bus.stall_cnt !== exp_cnt) begin n_fail++; $display("FAIL cnt3: got %0d want %0d", bus.stall_cnt, exp_cnt); end
    set_nop();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_chk++; if (bus.stall_cnt !== 32'd0) begin n_fail++; $display("FAIL cnt_reset: got %0d want 0", bus.stall_cnt); end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    set_nop();
    test_reset();
    test_e_fwd();
    test_load_use();
    test_r0();
    test_e_wins();
    test_two_ahead();
    test_jal();
    test_shift_imm();
    test_stall_flush();
    test_reset_mid_stall();
    test_stall_cnt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
